// File: rtl/vector_sequencer.sv
// Clocked exhaustive-sweep checker for a small combinational block: steps every input vector,
// waits a settle time, compares the output to a truth table. Optional: VECSEQ_STOP_ON_FAIL_EN.
module vector_sequencer #(
    parameter int                    N_IN          = 3,
    parameter int                    SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0]    EXPECTED      = 8'b1001_0110
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dut_y,
    output logic [N_IN-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail
);

    localparam int              CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              mismatch;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        mismatch = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    cnt_d   = RELOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHECK: begin
                mismatch = (dut_y != EXPECTED[vec_q]);
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) ff_d = vec_q;
                end
`ifdef VECSEQ_STOP_ON_FAIL_EN
                if (mismatch || vec_q == LAST_VEC) begin
`else
                if (vec_q == LAST_VEC) begin
`endif
                    state_d = S_FINISH;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = RELOAD;
                    state_d = S_SETTLE;
                end
            end
            S_FINISH: begin
                // done and pass are registered, so they appear together one cycle after FINISH
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign dut_in     = vec_q;
    assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
